// File: rtl/tx_msg_seq_if.sv
// tx_msg_seq_if: byte handshake between the status-line sequencer and the
// UART TX shifter.
//   oTX_DATA  : byte offered to the UART (sequencer -> UART)
//   oTX_VALID : oTX_DATA is valid        (sequencer -> UART)
//   iTX_READY : UART accepts the byte    (UART -> sequencer)
// A byte transfers on a clock edge where oTX_VALID & iTX_READY.
interface tx_msg_seq_if;
    logic [7:0] oTX_DATA;
    logic       oTX_VALID;
    logic       iTX_READY;

    modport master (output oTX_DATA, output oTX_VALID, input iTX_READY);
    modport slave  (input oTX_DATA, input oTX_VALID, output iTX_READY);
endinterface

// File: rtl/tx_msg_seq.sv
// tx_msg_seq: streams one ASCII status line per frame to the UART:
//   "current state:rate control  rate:" <decimal rate> <EOL>
// The rate is latched at frame start, converted to BCD by a serial
// double-dabble (one input bit per cycle), and printed with leading zeros
// suppressed. Values above 10^RATE_DIGITS-1 print as all nines.
//
// Ports:
//   clk       : clock, all logic on posedge
//   reset     : synchronous active-high reset
//   iSTART    : frame request, sampled only in IDLE
//   iABORT    : cancel the current frame
//   iREPEAT   : start a new frame right after the terminator
//   iRATE_VAL : binary rate value
//   tx        : byte handshake (oTX_DATA / oTX_VALID / iTX_READY)
//   oBUSY     : high in any state other than IDLE
//   oDONE     : one-cycle pulse after the frame's last byte is accepted
//
// Optional feature: define TX_MSG_CRLF_EN to terminate lines with 0D 0A
// instead of 0A alone.
module tx_msg_seq #(
    parameter int         RATE_W      = 16,
    parameter int         RATE_DIGITS = 5,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iSTART,
    input  logic              iABORT,
    input  logic              iREPEAT,
    input  logic [RATE_W-1:0] iRATE_VAL,
    tx_msg_seq_if.master      tx,
    output logic              oBUSY,
    output logic              oDONE
);
    localparam int PREFIX_LEN = 33;
    localparam logic [PREFIX_LEN*8-1:0] PREFIX = "current state:rate control  rate:";
    localparam int CNT_W = $clog2(RATE_W + 1);
    localparam int DI_W  = (RATE_DIGITS > 1) ? $clog2(RATE_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(RATE_W);
    localparam logic [5:0]       PREFIX_LAST = 6'(PREFIX_LEN - 1);
    localparam logic [DI_W-1:0]  DIG_LAST    = DI_W'(RATE_DIGITS - 1);

    function automatic longint unsigned pow10m1(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p - 1;
    endfunction

    localparam longint unsigned MAX_VAL = pow10m1(RATE_DIGITS);

    typedef enum logic [2:0] {IDLE, CONV, PREFIX_S, DIGITS, EOL} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         bitCnt;
    logic [5:0]               byteIdx;
    logic [DI_W-1:0]          digIdx;
    logic [RATE_W-1:0]        rateSh;
    logic [RATE_DIGITS*4-1:0] bcd;
    logic [RATE_DIGITS*4-1:0] bcdAdj;
    logic [DI_W-1:0]          firstDig;
    logic [DI_W-1:0]          startDig;
    logic                     sat;
    logic                     xfer;
`ifdef TX_MSG_CRLF_EN
    logic                     crSent;
`endif

    function automatic logic [7:0] prefixByte(input logic [5:0] idx);
        return PREFIX[(PREFIX_LEN - 1 - int'(idx))*8 +: 8];
    endfunction

    function automatic logic [7:0] digByte(input logic [RATE_DIGITS*4-1:0] b,
                                           input logic s,
                                           input logic [DI_W-1:0] i);
        return s ? 8'h39 : {4'h3, b[int'(i)*4 +: 4]};
    endfunction

    // Double-dabble add-3 step applied before each shift.
    always_comb begin
        bcdAdj = bcd;
        for (int d = 0; d < RATE_DIGITS; d++)
            if (bcd[d*4 +: 4] >= 4'd5) bcdAdj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end

    // Most significant non-zero digit; digit 0 when the value is zero so a
    // single '0' is printed. Saturated values print every slot.
    always_comb begin
        firstDig = '0;
        for (int d = 0; d < RATE_DIGITS; d++)
            if (bcd[d*4 +: 4] != 4'd0) firstDig = DI_W'(d);
        startDig = sat ? DIG_LAST : firstDig;
    end

    assign xfer = tx.oTX_VALID & tx.iTX_READY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tx.oTX_DATA  <= IDLE_BYTE;
            tx.oTX_VALID <= 1'b0;
            oBUSY        <= 1'b0;
            oDONE        <= 1'b0;
            bitCnt       <= '0;
            byteIdx      <= '0;
            digIdx       <= '0;
            rateSh       <= '0;
            bcd          <= '0;
            sat          <= 1'b0;
`ifdef TX_MSG_CRLF_EN
            crSent       <= 1'b0;
`endif
        end else begin
            oDONE <= 1'b0;
            if (state != IDLE && iABORT) begin
                // Abort wins even over a transfer on this edge.
                state        <= IDLE;
                tx.oTX_VALID <= 1'b0;
                tx.oTX_DATA  <= IDLE_BYTE;
                oBUSY        <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (iSTART && !iABORT) begin
                        state  <= CONV;
                        oBUSY  <= 1'b1;
                        rateSh <= iRATE_VAL;
                        bcd    <= '0;
                        bitCnt <= '0;
                        sat    <= (64'(iRATE_VAL) > MAX_VAL);
                    end
                    // RATE_W shift cycles, then one cycle to present the
                    // first prefix byte once the BCD result is final.
                    CONV: if (bitCnt != CONV_LAST) begin
                        {bcd, rateSh} <= {bcdAdj, rateSh} << 1;
                        bitCnt        <= bitCnt + 1'b1;
                    end else begin
                        state        <= PREFIX_S;
                        byteIdx      <= '0;
                        tx.oTX_VALID <= 1'b1;
                        tx.oTX_DATA  <= prefixByte(6'd0);
                    end
                    PREFIX_S: if (xfer) begin
                        if (byteIdx == PREFIX_LAST) begin
                            state       <= DIGITS;
                            digIdx      <= startDig;
                            tx.oTX_DATA <= digByte(bcd, sat, startDig);
                        end else begin
                            byteIdx     <= byteIdx + 1'b1;
                            tx.oTX_DATA <= prefixByte(byteIdx + 1'b1);
                        end
                    end
                    DIGITS: if (xfer) begin
                        if (digIdx == '0) begin
                            state <= EOL;
`ifdef TX_MSG_CRLF_EN
                            crSent      <= 1'b0;
                            tx.oTX_DATA <= 8'h0D;
`else
                            tx.oTX_DATA <= 8'h0A;
`endif
                        end else begin
                            digIdx      <= digIdx - 1'b1;
                            tx.oTX_DATA <= digByte(bcd, sat, digIdx - 1'b1);
                        end
                    end
                    EOL: if (xfer) begin
`ifdef TX_MSG_CRLF_EN
                        if (!crSent) begin
                            crSent      <= 1'b1;
                            tx.oTX_DATA <= 8'h0A;
                        end else
`endif
                        begin
                            oDONE        <= 1'b1;
                            tx.oTX_VALID <= 1'b0;
                            tx.oTX_DATA  <= IDLE_BYTE;
                            if (iREPEAT) begin
                                state  <= CONV;
                                rateSh <= iRATE_VAL;
                                bcd    <= '0;
                                bitCnt <= '0;
                                sat    <= (64'(iRATE_VAL) > MAX_VAL);
                            end else begin
                                state <= IDLE;
                                oBUSY <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        tx.oTX_VALID <= 1'b0;
                        tx.oTX_DATA  <= IDLE_BYTE;
                        oBUSY        <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tx_msg_seq.sv
module tb_tx_msg_seq;
    localparam int RATE_W = 17;
    localparam int RATE_DIGITS = 5;
`ifdef TX_MSG_CRLF_EN
    localparam int EOL_LEN = 2;
    string EOL_S = "^|";
`else
    localparam int EOL_LEN = 1;
    string EOL_S = "|";
`endif
    string PFX = "current state:rate control  rate:";

    logic clk = 0;
    logic reset, iSTART, iABORT, iREPEAT;
    logic [RATE_W-1:0] iRATE_VAL;
    logic oBUSY, oDONE;
    tx_msg_seq_if txIf();

    tx_msg_seq #(.RATE_W(RATE_W), .RATE_DIGITS(RATE_DIGITS), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .reset(reset), .iSTART(iSTART), .iABORT(iABORT), .iREPEAT(iREPEAT),
        .iRATE_VAL(iRATE_VAL), .tx(txIf.master), .oBUSY(oBUSY), .oDONE(oDONE));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int doneCnt = 0;
    logic [7:0] rxq[$];
    bit holdPend = 0;
    logic [7:0] holdData;

    // Collects accepted bytes, counts done pulses, checks hold-under-stall
    // and the idle byte value.
    always @(negedge clk) begin
        if (reset) holdPend = 0;
        else begin
            if (holdPend) begin
                checks++;
                if (!(txIf.oTX_VALID && txIf.oTX_DATA == holdData)) begin
                    errors++;
                    $display("FAIL hold: got valid=%0b data=%h want valid=1 data=%h",
                             txIf.oTX_VALID, txIf.oTX_DATA, holdData);
                end
            end
            if (!txIf.oTX_VALID) begin
                checks++;
                if (txIf.oTX_DATA !== 8'hFF) begin
                    errors++;
                    $display("FAIL idle_byte: got %h want ff", txIf.oTX_DATA);
                end
            end
            holdPend = txIf.oTX_VALID && !txIf.iTX_READY && !iABORT;
            holdData = txIf.oTX_DATA;
            if (txIf.oTX_VALID && txIf.iTX_READY) rxq.push_back(txIf.oTX_DATA);
            if (oDONE) doneCnt++;
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_s(input string name, input string got, input string want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, got, want);
        end
    endtask

    function automatic string rx_str();
        string s = "";
        foreach (rxq[i]) begin
            logic [7:0] c;
            c = (rxq[i] == 8'h0A) ? 8'h7C : (rxq[i] == 8'h0D) ? 8'h5E : rxq[i];
            s = $sformatf("%s%c", s, c);
        end
        return s;
    endfunction

    // Reference: decimal text of the value, clamped to the digit field.
    function automatic string model_digits(input longint v);
        if (v > 99999) return "99999";
        return $sformatf("%0d", v);
    endfunction

    function automatic logic pick_ready(input int mode, input int c);
        case (mode)
            0: return 1'b1;
            1: return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Runs one frame from start to IDLE; returns first-valid latency.
    task automatic run_frame(input logic [RATE_W-1:0] v, input int mode, input bit noise,
                             output int lat, output int dn);
        int d0;
        bit fin = 0;
        rxq.delete();
        d0 = doneCnt;
        iRATE_VAL = v; iSTART = 1;
        @(posedge clk); #1;
        iSTART = 0;
        lat = -1;
        for (int c = 0; c < 600; c++) begin
            txIf.iTX_READY = pick_ready(mode, c);
            iRATE_VAL = RATE_W'($urandom);
            if (noise) iSTART = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            if (lat < 0 && txIf.oTX_VALID) lat = c + 1;
            if (!oBUSY) begin fin = 1; break; end
        end
        iSTART = 0;
        if (!fin) begin
            errors++; checks++;
            $display("FAIL frame_timeout: got busy=1 want busy=0");
        end
        @(negedge clk); #1;
        dn = doneCnt - d0;
    endtask

    typedef struct {
        logic [RATE_W-1:0] rate;
        int    mode;
        string digits;
        int    len;   // with a single-byte terminator
    } vec_t;

    initial begin
        vec_t tbl[10];
        int lat, dn, d0;
        string exp1;
        bit busyDrop;

        tbl[0] = '{115,    0, "115",   37};
        tbl[1] = '{0,      0, "0",     35};
        tbl[2] = '{100000, 0, "99999", 39};
        tbl[3] = '{99999,  1, "99999", 39};
        tbl[4] = '{7,      0, "7",     35};
        tbl[5] = '{10,     2, "10",    36};
        tbl[6] = '{131071, 2, "99999", 39};
        tbl[7] = '{1000,   1, "1000",  38};
        tbl[8] = '{65535,  0, "65535", 39};
        tbl[9] = '{9,      1, "9",     35};

        reset = 1; iSTART = 0; iABORT = 0; iREPEAT = 0; iRATE_VAL = '0;
        txIf.iTX_READY = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", txIf.oTX_VALID, 0);
        chk("reset_data", txIf.oTX_DATA, 8'hFF);
        chk("reset_busy", oBUSY, 0);
        chk("reset_done", oDONE, 0);
        reset = 0;

        // Start with abort in IDLE is ignored.
        iSTART = 1; iABORT = 1; iRATE_VAL = 5;
        @(posedge clk); #1;
        iSTART = 0; iABORT = 0;
        chk("start_with_abort_ignored", oBUSY, 0);

        foreach (tbl[i]) begin
            run_frame(tbl[i].rate, tbl[i].mode, 0, lat, dn);
            chk("latency", lat, RATE_W + 1);
            chk("frame_len", rxq.size(), tbl[i].len + EOL_LEN - 1);
            chk_s("frame_text", rx_str(), {PFX, tbl[i].digits, EOL_S});
            chk("done_pulses", dn, 1);
            chk("end_valid", txIf.oTX_VALID, 0);
            chk("end_data", txIf.oTX_DATA, 8'hFF);
        end

        // Randomized frames with stalls and ignored mid-frame starts.
        for (int k = 0; k < 20; k++) begin
            logic [RATE_W-1:0] v;
            case ($urandom_range(0, 2))
                0: v = RATE_W'($urandom_range(0, 20));
                1: v = RATE_W'($urandom_range(0, 99999));
                default: v = RATE_W'($urandom);
            endcase
            run_frame(v, 2, 1, lat, dn);
            chk("rnd_latency", lat, RATE_W + 1);
            chk_s("rnd_text", rx_str(), {PFX, model_digits(longint'(v)), EOL_S});
            chk("rnd_done", dn, 1);
        end

        // Repeat: second frame latches the value present at the terminator.
        rxq.delete();
        d0 = doneCnt;
        busyDrop = 1;
        iREPEAT = 1; iRATE_VAL = 5; iSTART = 1;
        @(posedge clk); #1;
        iSTART = 0; iRATE_VAL = 10;
        for (int c = 0; c < 1000; c++) begin
            txIf.iTX_READY = 1;
            iREPEAT = (doneCnt == d0);
            @(posedge clk); #1;
            if (!oBUSY) begin busyDrop = (rxq.size() != 2*(33 + EOL_LEN) + 3); break; end
        end
        iREPEAT = 0;
        @(negedge clk); #1;
        chk_s("repeat_text", rx_str(), {PFX, "5", EOL_S, PFX, "10", EOL_S});
        chk("repeat_done", doneCnt - d0, 2);
        chk("repeat_busy_held", busyDrop, 0);

        // Abort while byte 20 is offered and accepted.
        rxq.delete();
        d0 = doneCnt;
        iRATE_VAL = 115; iSTART = 1; txIf.iTX_READY = 1;
        @(posedge clk); #1;
        iSTART = 0;
        for (int c = 0; c < 200 && rxq.size() < 20; c++) begin
            @(posedge clk); #1;
        end
        chk("abort_at_20", rxq.size(), 20);
        iABORT = 1;
        @(posedge clk); #1;
        iABORT = 0;
        chk("abort_valid", txIf.oTX_VALID, 0);
        chk("abort_busy", oBUSY, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", doneCnt - d0, 0);
        chk("abort_bytes", rxq.size(), 21);
        chk("abort_stays_idle", txIf.oTX_VALID, 0);

        // Reset mid-digits.
        rxq.delete();
        iRATE_VAL = 115; iSTART = 1;
        @(posedge clk); #1;
        iSTART = 0;
        for (int c = 0; c < 200 && rxq.size() < 34; c++) begin
            @(posedge clk); #1;
        end
        reset = 1;
        @(posedge clk); #1;
        chk("midrst_valid", txIf.oTX_VALID, 0);
        chk("midrst_data", txIf.oTX_DATA, 8'hFF);
        chk("midrst_busy", oBUSY, 0);
        chk("midrst_done", oDONE, 0);
        reset = 0;
        @(posedge clk); #1;
        run_frame(42, 1, 0, lat, dn);
        chk_s("post_reset_text", rx_str(), {PFX, "42", EOL_S});
        chk("post_reset_done", dn, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
